// File: rtl/mul_div_unit_pkg.sv
// Shared constants for the multiply/divide unit: funct codes, FSM encoding and
// the issue-to-writeback latency that execute-stage hazard logic relies on.
package mul_div_unit_pkg;

    localparam logic [5:0] FUN_MULT  = 6'h18;
    localparam logic [5:0] FUN_MULTU = 6'h19;
    localparam logic [5:0] FUN_DIV   = 6'h1A;
    localparam logic [5:0] FUN_DIVU  = 6'h1B;
    localparam logic [5:0] FUN_ADD   = 6'h20;

    localparam int MDU_WIDTH   = 32;
    localparam int MDU_LATENCY = MDU_WIDTH + 2;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIX  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_t;

    function automatic logic is_mdu_funct(input logic [5:0] funct);
        return (funct == FUN_MULT) || (funct == FUN_MULTU) ||
               (funct == FUN_DIV)  || (funct == FUN_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/writeback bundle between the execute stage (master) and the
// multiply/divide unit (slave); result fields feed the LO/HI write port.
interface mul_div_unit_if #(parameter int WIDTH = 32);

    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             busy;
    logic             writeLoHi;
    logic [WIDTH-1:0] writeData;
    logic [WIDTH-1:0] writeDataHi;

    modport master (
        output start, funct, srcA, srcB,
        input  busy, writeLoHi, writeData, writeDataHi
    );

    modport slave (
        input  start, funct, srcA, srcB,
        output busy, writeLoHi, writeData, writeDataHi
    );

endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one bit per cycle on magnitudes, sign
// fix-up afterwards, then a one-cycle LO/HI write strobe.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           reset,
    mul_div_unit_if.slave bus
);

    localparam logic [5:0] LAST_COUNT = 6'(WIDTH - 1);

    mdu_state_t         state;
    logic [5:0]         counter;
    logic               is_div;
    logic               is_signed;
    logic               sign_a;
    logic               sign_b;
    logic               div_zero;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;
    logic               busy_q;
    logic               write_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   hi_q;

    logic               accept;
    logic               in_signed;
    logic               in_div;
    logic               in_sign_a;
    logic               in_sign_b;
    logic [WIDTH-1:0]   in_mag_a;
    logic [WIDTH-1:0]   in_mag_b;
    logic [WIDTH:0]     add_a;
    logic [WIDTH:0]     add_b;
    logic               add_cin;
    logic [WIDTH+1:0]   add_sum;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_lo;
    logic [WIDTH-1:0]   res_hi;
    logic               negate;

    assign bus.busy        = busy_q;
    assign bus.writeLoHi   = write_q;
    assign bus.writeData   = lo_q;
    assign bus.writeDataHi = hi_q;

    assign accept = bus.start && (state == MDU_IDLE) && is_mdu_funct(bus.funct);

    always_comb begin
        // NOTE: every signal gets a default up front so no path leaves one unassigned (no latch).
        in_signed = (bus.funct == FUN_MULT) || (bus.funct == FUN_DIV);
        in_div    = (bus.funct == FUN_DIV)  || (bus.funct == FUN_DIVU);
        in_sign_a = in_signed && bus.srcA[WIDTH-1];
        in_sign_b = in_signed && bus.srcB[WIDTH-1];
        in_mag_a  = in_sign_a ? -bus.srcA : bus.srcA;
        in_mag_b  = in_sign_b ? -bus.srcB : bus.srcB;

        // Shared adder: multiply adds the multiplicand into the high half,
        // divide subtracts the divisor from the left-shifted remainder.
        add_a   = {1'b0, acc[2*WIDTH-1:WIDTH]};
        add_b   = {1'b0, mag_a};
        add_cin = 1'b0;
        if (is_div) begin
            add_a   = acc[2*WIDTH-1:WIDTH-1];
            add_b   = ~{1'b0, mag_b};
            add_cin = 1'b1;
        end
        add_sum = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};

        acc_next = acc;
        if (is_div) begin
            if (add_sum[WIDTH+1]) acc_next = {add_sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else                  acc_next = {acc[2*WIDTH-2:0], 1'b0};
        end else begin
            if (acc[0]) acc_next = {add_sum[WIDTH:0], acc[WIDTH-1:1]};
            else        acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end

        negate = is_signed && (sign_a ^ sign_b);
        prod   = negate ? -acc : acc;
        res_lo = prod[WIDTH-1:0];
        res_hi = prod[2*WIDTH-1:WIDTH];
        if (is_div) begin
            res_lo = div_zero ? {WIDTH{1'b1}}
                              : (negate ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
            res_hi = (is_signed && sign_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= MDU_IDLE;
            counter   <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            div_zero  <= 1'b0;
            mag_a     <= '0;
            mag_b     <= '0;
            acc       <= '0;
            busy_q    <= 1'b0;
            write_q   <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
        end else begin
            case (state)
                MDU_IDLE: begin
                    if (accept) begin
                        is_div    <= in_div;
                        is_signed <= in_signed;
                        sign_a    <= in_sign_a;
                        sign_b    <= in_sign_b;
                        div_zero  <= (bus.srcB == '0);
                        mag_a     <= in_mag_a;
                        mag_b     <= in_mag_b;
                        acc       <= {{WIDTH{1'b0}}, (in_div ? in_mag_a : in_mag_b)};
                        counter   <= '0;
                        busy_q    <= 1'b1;
                        state     <= MDU_CALC;
                    end
                end
                MDU_CALC: begin
                    acc     <= acc_next;
                    counter <= counter + 6'd1;
                    if (counter == LAST_COUNT) begin
                        counter <= '0;
                        state   <= MDU_FIX;
                    end
                end
                MDU_FIX: begin
                    lo_q    <= res_lo;
                    hi_q    <= res_hi;
                    write_q <= 1'b1;
                    state   <= MDU_DONE;
                end
                MDU_DONE: begin
                    write_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= MDU_IDLE;
                end
                default: state <= MDU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and randomized checks of mul_div_unit against an arithmetic
// reference model of MULT/MULTU/DIV/DIVU including divide-by-zero rules.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    mul_div_unit_if #(.WIDTH(32)) bus();

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi);
        logic [63:0] p;
        longint      sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        lo = '0;
        hi = '0;
        case (f)
            FUN_MULTU: begin p = {32'b0, a} * {32'b0, b}; lo = p[31:0]; hi = p[63:32]; end
            FUN_MULT:  begin p = sa * sb;                 lo = p[31:0]; hi = p[63:32]; end
            FUN_DIVU: begin
                if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
            FUN_DIV: begin
                if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    lo = q[31:0];
                    hi = r[31:0];
                end
            end
            default: ;
        endcase
    endfunction

    // Caller must be just past a falling edge; returns at the falling edge of
    // cycle k+35 so another op can be issued immediately.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input bit inject);
        logic [31:0] exp_lo, exp_hi, got_lo, got_hi;
        int pulses, pulse_at, busy_bad;
        model(f, a, b, exp_lo, exp_hi);
        pulses = 0; pulse_at = -1; busy_bad = 0; got_lo = 'x; got_hi = 'x;
        bus.start = 1'b1; bus.funct = f; bus.srcA = a; bus.srcB = b;
        for (int n = 1; n <= 35; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
            if (inject && n == 5) begin
                bus.start = 1'b1; bus.funct = FUN_MULTU; bus.srcA = 32'd2; bus.srcB = 32'd2;
            end
            if (inject && n == 6) bus.start = 1'b0;
            if (bus.busy !== (n <= 34)) busy_bad++;
            if (bus.writeLoHi === 1'b1) begin
                pulses++; pulse_at = n; got_lo = bus.writeData; got_hi = bus.writeDataHi;
            end
        end
        check({tag, " pulse_cycle"}, 32'(pulse_at), 32'd34);
        check({tag, " pulse_count"}, 32'(pulses), 32'd1);
        check({tag, " busy_window"}, 32'(busy_bad), 32'd0);
        check({tag, " lo"}, got_lo, exp_lo);
        check({tag, " hi"}, got_hi, exp_hi);
        check({tag, " lo_hold"}, bus.writeData, exp_lo);
    endtask

    initial begin
        logic [5:0]  f;
        logic [31:0] a, b;
        int          pulses, busy_cnt;

        reset = 1'b1;
        bus.start = 1'b0; bus.funct = '0; bus.srcA = '0; bus.srcB = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset strobe", 32'(bus.writeLoHi), 32'd0);
        check("reset lo", bus.writeData, 32'd0);
        check("reset hi", bus.writeDataHi, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed operations, issued back to back at k+35.
        run_op(FUN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1'b0);
        run_op(FUN_MULT,  32'hFFFF_FFFD, 32'd5,         "mult_neg", 1'b0);
        run_op(FUN_MULT,  32'd0,         32'h8000_0000, "mult_zero", 1'b0);
        run_op(FUN_DIV,   32'hFFFF_FFF9, 32'd2,         "div_neg", 1'b0);
        run_op(FUN_DIVU,  32'd7,         32'd2,         "divu_small", 1'b0);
        run_op(FUN_DIVU,  32'hFFFF_FFF9, 32'd2,         "divu_big", 1'b0);
        run_op(FUN_DIV,   32'h0000_1234, 32'd0,         "div_by_zero", 1'b0);
        run_op(FUN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_overflow", 1'b0);
        run_op(FUN_DIV,   32'hFFFF_FF00, 32'd0,         "div_neg_by_zero", 1'b0);
        run_op(FUN_DIVU,  32'd100,       32'd7,         "start_while_busy", 1'b1);
        run_op(FUN_MULTU, 32'd3,         32'd4,         "back_to_back", 1'b0);

        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 3))
                0:       f = FUN_MULT;
                1:       f = FUN_MULTU;
                2:       f = FUN_DIV;
                default: f = FUN_DIVU;
            endcase
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            run_op(f, a, b, $sformatf("rnd%0d", i), 1'b0);
        end

        // A non-MDU funct must not occupy the unit or disturb the held result.
        bus.start = 1'b1; bus.funct = FUN_ADD; bus.srcA = 32'd1; bus.srcB = 32'd1;
        model(f, a, b, a, b);
        pulses = 0; busy_cnt = 0;
        for (int n = 1; n <= 36; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.writeLoHi === 1'b1) pulses++;
        end
        check("bad_funct busy", 32'(busy_cnt), 32'd0);
        check("bad_funct pulse", 32'(pulses), 32'd0);
        check("bad_funct lo_hold", bus.writeData, a);
        check("bad_funct hi_hold", bus.writeDataHi, b);

        // Reset in the middle of a divide.
        bus.start = 1'b1; bus.funct = FUN_DIVU; bus.srcA = 32'd100; bus.srcB = 32'd7;
        pulses = 0; busy_cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
            if (n == 10) reset = 1'b1;
            if (n == 11) begin
                reset = 1'b0;
                check("abort busy", 32'(bus.busy), 32'd0);
                check("abort lo", bus.writeData, 32'd0);
                check("abort hi", bus.writeDataHi, 32'd0);
            end
            if (n >= 11 && bus.busy === 1'b1) busy_cnt++;
            if (bus.writeLoHi === 1'b1) pulses++;
        end
        check("abort pulse", 32'(pulses), 32'd0);
        check("abort busy_after", 32'(busy_cnt), 32'd0);

        // Start coinciding with reset is dropped.
        bus.start = 1'b1; bus.funct = FUN_MULTU; bus.srcA = 32'd3; bus.srcB = 32'd4;
        reset = 1'b1;
        pulses = 0; busy_cnt = 0;
        for (int n = 1; n <= 36; n++) begin
            @(negedge clk);
            if (n == 1) begin bus.start = 1'b0; reset = 1'b0; end
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.writeLoHi === 1'b1) pulses++;
        end
        check("start_reset busy", 32'(busy_cnt), 32'd0);
        check("start_reset pulse", 32'(pulses), 32'd0);

        run_op(FUN_MULT, 32'h7FFF_FFFF, 32'h8000_0000, "after_reset", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
